// File: rtl/painterengine_gpu_burst_reader_pkg.sv
// Shared definitions for the GPU burst reader: FSM encoding, AXI constants and the 4 KB burst splitter.
package painterengine_gpu_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4KB_WORDS  = 1024;
  localparam int         LEN_W          = 9;

  // Beats of the next burst: whatever is left, but never across a 4 KB page.
  function automatic logic [LEN_W-1:0] burst_beats(input logic [LEN_W-1:0] remaining,
                                                   input logic [9:0]       page_word_offset);
    logic [10:0] to_boundary;
    to_boundary = 11'(AXI_4KB_WORDS) - {1'b0, page_word_offset};
    burst_beats = ({2'b00, remaining} < to_boundary) ? remaining : to_boundary[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/painterengine_gpu_burst_reader_if.sv
// AXI4 read-only channel bundle (AR + R) between the burst reader and the HP port.
interface painterengine_gpu_burst_reader_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // A beat transfers on the rising edge where valid and ready are both high; the source holds
  // valid and its payload stable until then, and the sink may change ready at any time.
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/painterengine_gpu_reader_cache.sv
// Word cache: synchronous write port, asynchronous read port so the output follows the read index.
module painterengine_gpu_reader_cache #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_wire_axi_clock,
  input  logic             write_enable,
  input  logic [IDX_W-1:0] write_index,
  input  logic [DW-1:0]    write_data,
  input  logic [IDX_W-1:0] read_index,
  output logic [DW-1:0]    read_data
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge i_wire_axi_clock) begin
    if (write_enable) mem[write_index] <= write_data;
  end

  assign read_data = mem[read_index];
endmodule

// File: rtl/painterengine_gpu_burst_reader.sv
// AXI4 read master: fetches a 1..256 word span into a local cache, splitting bursts at 4 KB pages,
// then serves the words to the display stage one pop at a time.
module painterengine_gpu_burst_reader
  import painterengine_gpu_burst_reader_pkg::*;
#(
  parameter int PARAM_ADDRESS_WIDTH  = 32,
  parameter int PARAM_DATA_WIDTH     = 32,
  parameter int PARAM_CACHE_MAX_SIZE = 256
) (
  input  logic                           i_wire_axi_clock,
  input  logic                           i_wire_resetn,
  input  logic [PARAM_ADDRESS_WIDTH-1:0] i_wire_address,
  input  logic [LEN_W-1:0]               i_wire_length,
  input  logic                           i_wire_enable,
  output logic                           o_wire_done,
  output logic [PARAM_DATA_WIDTH-1:0]    o_wire_data,
  input  logic                           i_wire_data_next,
  output logic                           o_wire_error,
  output state_t                         o_wire_state,
  painterengine_gpu_burst_reader_if.master m_axi
);
  localparam int               IDX_W   = $clog2(PARAM_CACHE_MAX_SIZE);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PARAM_CACHE_MAX_SIZE);

  state_t                         state_q, state_next;
  logic [PARAM_ADDRESS_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]               len_q, remaining_q, wr_ptr_q, rd_ptr_q;
  logic [LEN_W-1:0]               len_clamped, beats, arlen_full;
  logic                           error_q, abort_q;
  logic                           draining, r_fire, cache_we;
  logic [PARAM_DATA_WIDTH-1:0]    cache_rdata;

  assign len_clamped = (i_wire_length > MAX_LEN) ? MAX_LEN : i_wire_length;
  assign beats       = burst_beats(remaining_q, addr_q[11:2]);
  assign arlen_full  = beats - 9'd1;
  // Once enable has dropped the request is dead, even if enable comes back mid-burst.
  assign draining    = abort_q | ~i_wire_enable;
  assign r_fire      = (state_q == ST_DATA) && m_axi.rvalid;
  assign cache_we    = r_fire && !draining && (wr_ptr_q < len_q);

  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = (state_q == ST_ADDR) ? arlen_full[7:0] : 8'd0;
  assign m_axi.arsize  = AXI_SIZE_4B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arvalid = (state_q == ST_ADDR);
  assign m_axi.rready  = (state_q == ST_DATA);

  assign o_wire_done  = (state_q == ST_DONE);
  assign o_wire_data  = o_wire_done ? cache_rdata : '0;
  assign o_wire_error = error_q;
  assign o_wire_state = state_q;

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: if (i_wire_enable) state_next = (len_clamped == '0) ? ST_DONE : ST_ADDR;
      ST_ADDR: if (m_axi.arready) state_next = ST_DATA;
      ST_DATA: begin
        if (r_fire && m_axi.rlast) begin
          if (draining)                 state_next = ST_IDLE;
          else if (remaining_q == '0)   state_next = ST_DONE;
          else                          state_next = ST_ADDR;
        end
      end
      ST_DONE: if (!i_wire_enable) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_axi_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      error_q     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q <= state_next;
      case (state_q)
        ST_IDLE: begin
          if (i_wire_enable) begin
            addr_q      <= i_wire_address;
            len_q       <= len_clamped;
            remaining_q <= len_clamped;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            error_q     <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (!i_wire_enable) abort_q <= 1'b1;
          if (m_axi.arready)  remaining_q <= remaining_q - beats;
        end
        ST_DATA: begin
          if (!i_wire_enable) abort_q <= 1'b1;
          if (r_fire) begin
            if (m_axi.rresp != AXI_RESP_OKAY) error_q <= 1'b1;
            if (cache_we) wr_ptr_q <= wr_ptr_q + 9'd1;
            addr_q <= addr_q + PARAM_ADDRESS_WIDTH'(4);
          end
        end
        ST_DONE: begin
          if (i_wire_data_next && (rd_ptr_q != len_q)) rd_ptr_q <= rd_ptr_q + 9'd1;
        end
        default: ;
      endcase
      if ((state_next == ST_IDLE) && (state_q != ST_IDLE)) begin
        error_q <= 1'b0;
        abort_q <= 1'b0;
      end
    end
  end

  painterengine_gpu_reader_cache #(
    .DEPTH (PARAM_CACHE_MAX_SIZE),
    .DW    (PARAM_DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_cache (
    .i_wire_axi_clock (i_wire_axi_clock),
    .write_enable     (cache_we),
    .write_index      (wr_ptr_q[IDX_W-1:0]),
    .write_data       (m_axi.rdata),
    .read_index       (rd_ptr_q[IDX_W-1:0]),
    .read_data        (cache_rdata)
  );
endmodule

// File: tb/tb_painterengine_gpu_burst_reader.sv
// Directed + randomized bench for the GPU burst reader against an AXI memory model and a split/data reference.
module tb_painterengine_gpu_burst_reader;
  import painterengine_gpu_burst_reader_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] address;
  logic [8:0]    length;
  logic          enable;
  logic          data_next;
  logic          done;
  logic          error;
  logic [DW-1:0] data;
  state_t        dbg_state;

  painterengine_gpu_burst_reader_if #(.AW(AW), .DW(DW)) axi ();

  painterengine_gpu_burst_reader #(
    .PARAM_ADDRESS_WIDTH  (AW),
    .PARAM_DATA_WIDTH     (DW),
    .PARAM_CACHE_MAX_SIZE (256)
  ) dut (
    .i_wire_axi_clock (clk),
    .i_wire_resetn    (rst_n),
    .i_wire_address   (address),
    .i_wire_length    (length),
    .i_wire_enable    (enable),
    .o_wire_done      (done),
    .o_wire_data      (data),
    .i_wire_data_next (data_next),
    .o_wire_error     (error),
    .o_wire_state     (dbg_state),
    .m_axi            (axi)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory model / AXI slave ----------------
  bit            full_rate = 1'b1;
  bit            inject_en = 1'b0;
  logic [AW-1:0] inject_addr = '0;
  logic [31:0]   salt = 32'h0;
  logic [AW-1:0] ar_addr_log[$];
  logic [7:0]    ar_len_log[$];
  int            beats_seen = 0;
  logic [AW-1:0] s_addr;
  int            s_left;
  bit            s_busy;
  bit            ar_pend;
  logic [AW-1:0] ar_prev_addr;
  logic [7:0]    ar_prev_len;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi.arready <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.rlast   <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= 2'b00;
      s_busy  = 1'b0;
      s_left  = 0;
      s_addr  = '0;
      ar_pend = 1'b0;
    end else begin
      if (ar_pend) begin
        check("ar_valid_held", axi.arvalid, 1'b1);
        check("ar_addr_stable", axi.araddr, ar_prev_addr);
        check("ar_len_stable", axi.arlen, ar_prev_len);
      end
      ar_pend      = axi.arvalid && !axi.arready;
      ar_prev_addr = axi.araddr;
      ar_prev_len  = axi.arlen;
      if (axi.arvalid && axi.arready) begin
        check("ar_single_outstanding", s_busy, 1'b0);
        ar_addr_log.push_back(axi.araddr);
        ar_len_log.push_back(axi.arlen);
        s_addr = axi.araddr;
        s_left = int'(axi.arlen) + 1;
        s_busy = 1'b1;
      end
      if (axi.rvalid && axi.rready) begin
        beats_seen++;
        s_addr = s_addr + 32'd4;
        s_left--;
        if (s_left == 0) s_busy = 1'b0;
      end
      if (!(axi.rvalid && !axi.rready)) begin
        if (s_busy && (full_rate || $urandom_range(0, 1) == 1)) begin
          axi.rvalid <= 1'b1;
          axi.rdata  <= mem_word(s_addr);
          axi.rlast  <= (s_left == 1);
          axi.rresp  <= (inject_en && s_addr == inject_addr) ? 2'b10 : 2'b00;
        end else begin
          axi.rvalid <= 1'b0;
          axi.rlast  <= 1'b0;
        end
      end
      axi.arready <= full_rate ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_quiet(input string tag);
    check({tag, "_done"},    done, 1'b0);
    check({tag, "_error"},   error, 1'b0);
    check({tag, "_arvalid"}, axi.arvalid, 1'b0);
    check({tag, "_rready"},  axi.rready, 1'b0);
    check({tag, "_araddr"},  axi.araddr, '0);
    check({tag, "_arlen"},   axi.arlen, '0);
    check({tag, "_data"},    data, '0);
    check({tag, "_state"},   dbg_state, ST_IDLE);
  endtask

  // Issues a request, checks the burst split against a page-walk model, pops every word and releases.
  task automatic run_request(input logic [AW-1:0] a, input logic [8:0] l, input bit exp_err,
                             output int cycles);
    int            n, rem, beats, nar;
    logic [AW-1:0] ea;
    n = (int'(l) > 256) ? 256 : int'(l);
    ar_addr_log.delete();
    ar_len_log.delete();
    address = a;
    length  = l;
    enable  = 1'b1;
    cycles  = 0;
    while (done !== 1'b1 && cycles < 4000) begin
      data_next = 1'($urandom_range(0, 1));
      @(negedge clk);
      cycles++;
    end
    data_next = 1'b0;
    check("done_reached", cycles < 4000, 1'b1);
    ea  = a;
    rem = n;
    nar = 0;
    while (rem > 0) begin
      beats = (4096 - int'(ea % 4096)) / 4;
      if (beats > rem) beats = rem;
      check("ar_present", ar_addr_log.size() > nar, 1'b1);
      if (ar_addr_log.size() > nar) begin
        check("araddr", ar_addr_log[nar], ea);
        check("arlen", ar_len_log[nar], 64'(beats - 1));
      end
      ea  = ea + 32'(4 * beats);
      rem = rem - beats;
      nar++;
    end
    check("ar_count", ar_addr_log.size(), 64'(nar));
    check("error_at_done", error, exp_err);
    for (int i = 0; i < n; i++) begin
      check("pop_data", data, mem_word(a + 32'(4 * i)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      data_next = 1'b1;
      @(negedge clk);
      data_next = 1'b0;
    end
    data_next = 1'b1;
    @(negedge clk);
    data_next = 1'b0;
    check("done_held", done, 1'b1);
    check("error_held", error, exp_err);
    enable = 1'b0;
    @(negedge clk);
    check("done_drop", done, 1'b0);
    check("error_idle_clear", error, 1'b0);
    check("state_idle", dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, base, wait_cyc;
    address   = '0;
    length    = '0;
    enable    = 1'b0;
    data_next = 1'b0;
    salt      = $urandom;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single aligned burst
    run_request(32'h0000_1000, 9'd16, 1'b0, cyc);
    // 4 KB split: 32 + 224 beats
    run_request(32'h0000_1F80, 9'd256, 1'b0, cyc);
    // empty request, then clamp with full-rate latency
    run_request(32'h0000_2000, 9'd0, 1'b0, cyc);
    check("len0_latency", cyc <= 2, 1'b1);
    run_request(32'h0000_4000, 9'd300, 1'b0, cyc);
    check("latency_256", cyc, 64'd258);

    // random stalls on both channels
    full_rate = 1'b0;
    run_request(32'h0000_5000 + (32'($urandom_range(0, 1023)) << 2), 9'd100, 1'b0, cyc);
    full_rate = 1'b1;

    // abort at beat 40 of 128, new request asserted while still draining
    ar_addr_log.delete();
    ar_len_log.delete();
    base     = beats_seen;
    address  = 32'h0000_3000;
    length   = 9'd128;
    enable   = 1'b1;
    wait_cyc = 0;
    while (beats_seen - base < 40 && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("abort_reached_beat40", wait_cyc < 1000, 1'b1);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_no_done", done, 1'b0);
    check("drain_single_ar", ar_addr_log.size(), 64'd1);
    check("drain_rready", axi.rready, 1'b1);
    run_request(32'h0000_3400, 9'd64, 1'b0, cyc);
    check("drain_total_beats", beats_seen - base, 64'(128 + 64));

    // SLVERR on beat 3, then a clean request
    inject_en   = 1'b1;
    inject_addr = 32'h0000_600C;
    run_request(32'h0000_6000, 9'd32, 1'b1, cyc);
    inject_en = 1'b0;
    run_request(32'h0000_6100, 9'd8, 1'b0, cyc);

    // asynchronous reset in the middle of a burst
    base     = beats_seen;
    address  = 32'h0000_7000;
    length   = 9'd64;
    enable   = 1'b1;
    wait_cyc = 0;
    while (beats_seen - base < 10 && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("mid_data_reached", dbg_state, ST_DATA);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized requests, alternating full rate and stalled slave
    for (int t = 0; t < 4; t++) begin
      full_rate = (t % 2 == 0);
      run_request(32'h0001_0000 + (32'($urandom_range(0, 2047)) << 2),
                  9'($urandom_range(1, 256)), 1'b0, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
